pc_counter_16bit: RTL and testbench
===================================

# pc_counter_16bit

Registered 16-bit up-counter stage that owns the counter state feeding the `Incrementer_16bit` ripple incrementer and latches its result every enabled cycle. A three-state FSM controls loading, counting up to a programmable limit, and holding. It reports completion, wrap-around and sticky overflow. It sits directly upstream of the incrementer and consumes its `Anew`/`Cout` outputs.

## Interface
- `WIDTH`, 16, counter width; fixed at 16 to match the incrementer.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load`  in  1  load `load_val` into the counter; highest priority after `rst`.
- `load_val`  in  16  value captured on `load`.
- `start`  in  1  begin or restart counting.
- `en`  in  1  count enable; sampled only in COUNT.
- `limit`  in  16  terminal count; sampled every cycle.
- `count`  out  16  current counter value (registered).
- `busy`  out  1  high while in COUNT.
- `done`  out  1  one-cycle pulse when the limit is reached.
- `wrap`  out  1  one-cycle pulse when the counter rolls from 16'hFFFF to 16'h0000.
- `ovf`  out  1  sticky overflow flag.

## Operation
- States: IDLE, COUNT, HOLD.
- Priority, per edge: `rst` > `load` > `start` > `en`.
- `rst`:
  - `count`=0, state IDLE.
  - `busy`, `done`, `wrap` and `ovf` all 0.
- `load` (any state):
  - `count`<=`load_val`, state IDLE.
  - `ovf`<=0; `done` and `wrap` 0.
- IDLE:
  - `busy`=0.
  - `start` -> COUNT; `count` unchanged, so counting begins from the reset or loaded value.
- COUNT:
  - `busy`=1.
  - `en`=0: hold `count` and state.
  - `en`=1 and `count`!=`limit`: `count`<=`Anew` (count+1).
  - If `Cout`=1 on that step (count was 16'hFFFF): `count` becomes 0, `wrap` pulses, `ovf`<=1, and counting continues.
  - `en`=1 and `count`==`limit`: `count` is held, `done` pulses, state -> HOLD.
  - `start` is ignored.
- HOLD:
  - `busy`=0; `count` held at `limit`.
  - `start` -> `count`<=0, state COUNT.
- Arithmetic: the incrementer is always driven with `count`. Its sum is taken modulo 2^16. No other adder is present.
- Starting above `limit` is legal. The counter wraps through 0 and then reaches `limit`, with `ovf` set.
- `limit` changing mid-count takes effect on the next comparison. No latching.

## Timing
- All outputs are registered. `done` and `wrap` are high for exactly one cycle, the cycle after the causing edge.
- `count` reflects an enabled increment one cycle after the edge where `en`=1 is sampled. Increment latency is 1 cycle.
- `start` in IDLE: `busy`=1 from the next cycle. The first increment can occur on the edge after that.
- `load` and `start` in the same cycle: `load` wins, state IDLE, `start` is lost.
- `rst` mid-count: all outputs return to reset values on the next edge. Any pending `done`/`wrap` pulse is suppressed.
- `limit`==16'hFFFF: the final step reaches FFFF, which is the limit. Neither `wrap` nor `ovf` fires.
- Combinational path: `count` -> 16-stage ripple incrementer -> `count` D-input. This path sets the clock period.

## Structure
- Shared package holds:
  - `CNT_W` = 16.
  - State enum `pc_state_t` {IDLE, COUNT, HOLD}.
- The single sub-module is the existing `Incrementer_16bit` (inputs `A`; outputs `Anew`, `Cout`), instantiated once. No second adder is allowed.
- Next-state logic and output registers sit in the top module.

## Test plan
- Reset, `load` 16'h0010, `limit` 16'h0013, `start`, `en`=1 -> `count` steps 10, 11, 12, 13; `done` pulses once; state HOLD; `busy`=0.
- `load` 16'hFFFE, `limit` 16'h0001, `start`, `en`=1 -> sequence FFFF, 0000 (`wrap`=1, `ovf`=1), 0001 with `done`. `ovf` stays 1 until the next `load`.
- In COUNT, toggle `en` 1,0,0,1 from 16'h0005 -> `count` 6, 6, 6, 7; no `done`.
- Assert `load` (16'h1234) and `start` in the same cycle during COUNT -> `count`=16'h1234, IDLE, `busy`=0, `ovf`=0.
- From HOLD at 16'h0013, pulse `start` -> `count`=0 and `busy`=1 next cycle; counting resumes to `limit`.
- Assert `rst` in the cycle `count`==`limit` with `en`=1 -> next cycle `count`=0, `done`=0, IDLE.

Source files
------------

// File: rtl/pc_counter_16bit_pkg.sv
// ---------------------------------------------------------------------------
// pc_counter_16bit_pkg
//   Shared definitions for the pc_counter_16bit stage.
//   CNT_W       : counter width, fixed at 16 to match Incrementer_16bit.
//   pc_state_t  : control FSM states (IDLE, COUNT, HOLD).
// ---------------------------------------------------------------------------
package pc_counter_16bit_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } pc_state_t;

endpackage : pc_counter_16bit_pkg

// File: rtl/pc_counter_16bit_incr.sv
// ---------------------------------------------------------------------------
// Incrementer_16bit
//   16-stage ripple incrementer: Anew = A + 1 (mod 2^16), Cout = carry out
//   of the top bit (high only when A == 16'hFFFF).
//   Ports:
//     A     in  16  operand
//     Anew  out 16  A + 1, modulo 2^16
//     Cout  out 1   carry out of bit 15
// ---------------------------------------------------------------------------
module Incrementer_16bit
   import pc_counter_16bit_pkg::*;
(
   input  logic [CNT_W-1:0] A,
   output logic [CNT_W-1:0] Anew,
   output logic             Cout
);

   // carry[i] is the carry into bit i; the chain is seeded with the +1.
   logic [CNT_W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < CNT_W; i++) begin : g_half_add
      assign Anew[i]    = A[i] ^ carry[i];
      assign carry[i+1] = A[i] & carry[i];
   end

   assign Cout = carry[CNT_W];

endmodule : Incrementer_16bit

// File: rtl/pc_counter_16bit.sv
// ---------------------------------------------------------------------------
// pc_counter_16bit
//   Registered 16-bit up-counter with load, start, enable and a programmable
//   terminal count. The single Incrementer_16bit instance always sees the
//   current count; its result is latched on every enabled COUNT step.
//
//   Handshake / control semantics: there is no valid/ready pair; each input
//   is a level sampled at the rising edge with priority rst > load > start >
//   en. done and wrap are single-cycle registered pulses; ovf is sticky until
//   the next load or rst.
//
//   Ports:
//     clk       in  1   clock, rising edge
//     rst       in  1   synchronous active-high reset
//     load      in  1   capture load_val, go IDLE, clear ovf
//     load_val  in  16  value captured on load
//     start     in  1   IDLE -> COUNT; HOLD -> COUNT from zero
//     en        in  1   count enable, used only in COUNT
//     limit     in  16  terminal count, compared every cycle
//     count     out 16  current counter value
//     busy      out 1   high while in COUNT
//     done      out 1   pulse: limit reached
//     wrap      out 1   pulse: counter rolled FFFF -> 0000
//     ovf       out 1   sticky wrap indicator
//     state     out 2   current FSM state (observation only)
// ---------------------------------------------------------------------------
module pc_counter_16bit
   import pc_counter_16bit_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             ovf,
   output pc_state_t        state
);

   logic [WIDTH-1:0] anew;
   logic             cout;

   // Only adder in the design; the count -> incrementer -> count path is
   // the critical path.
   Incrementer_16bit u_incr (
      .A    (count),
      .Anew (anew),
      .Cout (cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         // Pulses default low so they last exactly one cycle.
         done <= 1'b0;
         wrap <= 1'b0;
         if (load) begin
            count <= load_val;
            state <= IDLE;
            busy  <= 1'b0;
            ovf   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= COUNT;
                     busy  <= 1'b1;
                  end
               end
               COUNT: begin
                  if (en) begin
                     if (count == limit) begin
                        // Terminal count: hold value, report, park in HOLD.
                        done  <= 1'b1;
                        state <= HOLD;
                        busy  <= 1'b0;
                     end else begin
                        count <= anew;
                        if (cout) begin
                           wrap <= 1'b1;
                           ovf  <= 1'b1;
                        end
                     end
                  end
               end
               HOLD: begin
                  if (start) begin
                     count <= '0;
                     state <= COUNT;
                     busy  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : pc_counter_16bit

// File: tb/tb_pc_counter_16bit.sv
// ---------------------------------------------------------------------------
// tb_pc_counter_16bit
//   Directed test of pc_counter_16bit. Inputs are changed 1 time unit after
//   the rising edge and outputs are checked at the same point, so every
//   check sees the registered result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_pc_counter_16bit;
   import pc_counter_16bit_pkg::*;

   logic        clk = 1'b0;
   logic        rst, load, start, en;
   logic [15:0] load_val, limit;
   logic [15:0] count;
   logic        busy, done, wrap, ovf;
   pc_state_t   state;

   int total = 0;
   int bad   = 0;

   // -------------------------------------------------------- clock / reset
   always #5 clk = ~clk;

   pc_counter_16bit dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .en       (en),
      .limit    (limit),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap),
      .ovf      (ovf),
      .state    (state)
   );

   // -------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check every output at once.
   task automatic chk_all(input string tag, input logic [15:0] e_count,
                          input logic e_busy, input logic e_done,
                          input logic e_wrap, input logic e_ovf,
                          input pc_state_t e_state);
      chk({tag, ".count"}, count, e_count);
      chk({tag, ".busy"},  16'(busy),  16'(e_busy));
      chk({tag, ".done"},  16'(done),  16'(e_done));
      chk({tag, ".wrap"},  16'(wrap),  16'(e_wrap));
      chk({tag, ".ovf"},   16'(ovf),   16'(e_ovf));
      chk({tag, ".state"}, 16'(state), 16'(e_state));
   endtask

   // -------------------------------------------------------- directed steps
   initial begin
      rst = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0;
      load_val = 16'h0000; limit = 16'h0000;
      tick();
      tick();
      chk_all("reset", 16'h0000, 0, 0, 0, 0, IDLE);
      rst = 1'b0;

      // --- load 0x0010, limit 0x0013, count up to limit
      load = 1'b1; load_val = 16'h0010; limit = 16'h0013;
      tick();
      chk_all("ld10", 16'h0010, 0, 0, 0, 0, IDLE);
      load = 1'b0; start = 1'b1;
      tick();
      chk_all("start", 16'h0010, 1, 0, 0, 0, COUNT);
      start = 1'b0; en = 1'b1;
      tick(); chk_all("c11", 16'h0011, 1, 0, 0, 0, COUNT);
      tick(); chk_all("c12", 16'h0012, 1, 0, 0, 0, COUNT);
      tick(); chk_all("c13", 16'h0013, 1, 0, 0, 0, COUNT);
      tick(); chk_all("done13", 16'h0013, 0, 1, 0, 0, HOLD);
      tick(); chk_all("hold13", 16'h0013, 0, 0, 0, 0, HOLD);

      // --- restart from HOLD: count clears, runs back to limit
      start = 1'b1;
      tick();
      chk_all("restart", 16'h0000, 1, 0, 0, 0, COUNT);
      start = 1'b0;
      for (int i = 1; i <= 16'h13; i++) begin
         tick();
         chk("resume.count", count, 16'(i));
         chk("resume.done", 16'(done), 16'h0);
      end
      tick(); chk_all("redone", 16'h0013, 0, 1, 0, 0, HOLD);

      // --- wrap: load FFFE, limit 0001
      en = 1'b0; load = 1'b1; load_val = 16'hFFFE; limit = 16'h0001;
      tick(); chk_all("ldFFFE", 16'hFFFE, 0, 0, 0, 0, IDLE);
      load = 1'b0; start = 1'b1;
      tick(); chk_all("wstart", 16'hFFFE, 1, 0, 0, 0, COUNT);
      start = 1'b0; en = 1'b1;
      tick(); chk_all("wFFFF", 16'hFFFF, 1, 0, 0, 0, COUNT);
      tick(); chk_all("w0000", 16'h0000, 1, 0, 1, 1, COUNT);
      tick(); chk_all("w0001", 16'h0001, 1, 0, 0, 1, COUNT);
      tick(); chk_all("wdone", 16'h0001, 0, 1, 0, 1, HOLD);

      // --- restart from HOLD keeps ovf; count to 5, then toggle en
      start = 1'b1; limit = 16'h0100;
      tick(); chk_all("w2start", 16'h0000, 1, 0, 0, 1, COUNT);
      start = 1'b0;
      repeat (5) tick();
      chk_all("at5", 16'h0005, 1, 0, 0, 1, COUNT);
      en = 1'b1; tick(); chk_all("en1a", 16'h0006, 1, 0, 0, 1, COUNT);
      en = 1'b0; tick(); chk_all("en0a", 16'h0006, 1, 0, 0, 1, COUNT);
      en = 1'b0; tick(); chk_all("en0b", 16'h0006, 1, 0, 0, 1, COUNT);
      en = 1'b1; tick(); chk_all("en1b", 16'h0007, 1, 0, 0, 1, COUNT);

      // --- load and start together during COUNT: load wins, ovf clears
      load = 1'b1; start = 1'b1; load_val = 16'h1234;
      tick(); chk_all("ldstart", 16'h1234, 0, 0, 0, 0, IDLE);
      load = 1'b0; start = 1'b0;
      tick(); chk_all("ldidle", 16'h1234, 0, 0, 0, 0, IDLE);

      // --- limit FFFF: reaches FFFF without wrap or ovf
      load = 1'b1; load_val = 16'hFFFD; limit = 16'hFFFF;
      tick();
      load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); chk_all("lFFFE", 16'hFFFE, 1, 0, 0, 0, COUNT);
      tick(); chk_all("lFFFF", 16'hFFFF, 1, 0, 0, 0, COUNT);
      tick(); chk_all("ldone", 16'hFFFF, 0, 1, 0, 0, HOLD);

      // --- rst on the edge that would fire done
      load = 1'b1; load_val = 16'h0010; limit = 16'h0011;
      tick();
      load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); chk_all("r11", 16'h0011, 1, 0, 0, 0, COUNT);
      rst = 1'b1;
      tick(); chk_all("rstmid", 16'h0000, 0, 0, 0, 0, IDLE);
      rst = 1'b0;
      tick(); chk_all("postrst", 16'h0000, 0, 0, 0, 0, IDLE);

      // -------------------------------------------------------- report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pc_counter_16bit
